serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer that time-shares a single 1-bit adder cell across all bit positions of two WIDTH-bit operands.
- Accepts one operand pair through a valid/ready handshake and runs LSB-first for WIDTH cycles.
- Presents the sum and carry-out through a valid/ready handshake.
- Serves as the low-area arithmetic unit wherever a full parallel adder is not justified.

Parameters:
- WIDTH, 8, operand and sum width in bits (≥2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair (a, b, cin) valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - FSM state is IDLE; in_ready=1; out_valid=0; sum=0; cout=0.
  - Internal shift registers, carry flop and counter are all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, decoded from state.
  - On in_valid&&in_ready at edge T: latch a into a_sh, b into b_sh, cin into carry; set cnt=0; go to RUN.
  - Inputs are sampled only at the accepting edge; later changes are ignored.
- RUN:
  - in_ready=0.
  - Each cycle the cell computes s, co from a_sh[0], b_sh[0], carry.
  - At the edge: a_sh and b_sh shift right; sum_sh shifts right with s entering at the MSB; carry<=co; cnt++.
  - When cnt==WIDTH-1 at an edge: load sum<=final sum_sh and cout<=co, then go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_valid&&out_ready: go to IDLE, out_valid drops the next cycle.
  - out_ready held low stalls indefinitely; no new operands are accepted.
- Timing:
  - Accept at edge T gives out_valid=1 from cycle T+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles (one DONE cycle, one IDLE cycle).
- Counter: width $clog2(WIDTH). It never wraps past WIDTH-1; it is reloaded to 0 on accept.
- Arithmetic: sum is modulo 2^WIDTH. cout is the true carry, so {cout,sum} = a+b+cin exactly.
- Boundary cases:
  - in_valid asserted during RUN or DONE: ignored, no buffering.
  - out_ready high while out_valid=0: no effect.
  - rst during RUN or DONE: operation is aborted, no out_valid pulse; the next cycle is IDLE with in_ready=1.
  - rst and in_valid in the same cycle: reset wins, operands are dropped.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow.
  - ovf = carry into bit WIDTH-1 XOR cout. The carry into bit WIDTH-1 is captured during the final RUN cycle.
  - ovf is valid and held with out_valid; it resets to 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package serial_add_pkg:
  - State typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Localparam function for counter width.
- Sub-module full_add_cell:
  - Built from two half_adder instances plus an OR of their carries.
  - Inputs x, y, ci; outputs s, co.
  - serial_adder_ctrl instantiates exactly one of it.

Test Plan:
1. WIDTH=8, a=0x0F, b=0x01, cin=0 accepted at edge T → out_valid at T+8, sum=0x10, cout=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
3. Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands driven → sum/cout stable, in_ready=0, new operands ignored. After out_ready=1: IDLE, then next pair accepted.
4. Reset mid-run: rst asserted at 4th RUN cycle → out_valid never rises, in_ready=1 the following cycle, sum=0.
5. Back-to-back: 10 random pairs with out_ready tied 1 → each result equals a+b+cin; consecutive accepts spaced exactly 10 cycles.
6. With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 → sum=0x80, ovf=1. a=0xFF, b=0x01 → ovf=0, cout=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes and counter sizing.
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// One-bit full adder built from two half adders; this is the only arithmetic
// cell in the serial adder and is reused for every bit position.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_add_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1_s;
  logic c1_s;
  logic c2_s;

  half_adder u_ha0 (.x(x),    .y(y),  .s(s1_s), .c(c1_s));
  half_adder u_ha1 (.x(s1_s), .y(ci), .s(s),    .c(c2_s));

  assign co = c1_s | c2_s;

endmodule

// File: rtl/serial_adder_ctrl.sv
// LSB-first bit-serial adder sequencer with valid/ready on both sides.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] sum_shift_s;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_s;
  logic             cell_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_add_cell u_cell (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
  assign sum_shift_s = (sum_sh_q >> 1) | {cell_s, {(WIDTH-1){1'b0}}};

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = {WIDTH{1'b0}};
          carry_d  = cin;
          cnt_d    = {CW{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shift_s;
        carry_d  = cell_co;
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_shift_s;
          cout_d  = cell_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB during the final bit.
          ovf_d   = carry_q ^ cell_co;
`endif
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      sum_sh_q <= {WIDTH{1'b0}};
      sum_q    <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= {CW{1'b0}};
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
